// File: rtl/axi_self_test_ctrl.sv
// ============================================================================
// axi_self_test_ctrl : sequences reset, write and read phases of an AXI test
//                      master, watches its handshakes and reports pass/fail.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_self_test_ctrl #(
  parameter int RST_CYCLES       = 16,
  parameter int WBURSTS          = 64,
  parameter int RBURSTS_PER_PASS = 64,
  parameter int TIMEOUT          = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  num_passes,
  input  logic        bvalid,
  input  logic        bready,
  input  logic        arvalid,
  input  logic        arready,
  input  logic        rvalid,
  input  logic        rready,
  input  logic        rlast,
  input  logic        error,
  output logic        tst_rstn,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail_timeout,
  output logic        fail_order,
  output logic [15:0] wr_burst_cnt,
  output logic [7:0]  rd_pass_cnt,
  output logic [15:0] err_cnt
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] c_RST_LAST  = RCW'(RST_CYCLES - 1);
  localparam logic [15:0]    c_WBURSTS   = 16'(WBURSTS);
  localparam logic [15:0]    c_RD_LAST   = 16'(RBURSTS_PER_PASS - 1);
  localparam logic [15:0]    c_WDOG_LAST = 16'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_WR   = 2'd2,
    S_RD   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RCW-1:0]  r_rst_cnt;
  logic [15:0]     r_wr_cnt;
  logic [15:0]     r_rd_burst;
  logic [7:0]      r_rd_pass;
  logic [7:0]      r_passes;
  logic [15:0]     r_err;
  logic [15:0]     r_wdog;
  logic            r_done;
  logic            r_pass;
  logic            r_fail_to;
  logic            r_fail_ord;

  logic            w_b, w_ar, w_rl, w_hs;
  logic            w_in_wr, w_in_rd, w_active;
  logic            w_accept, w_abort, w_timeout, w_order;
  logic            w_pass_wrap, w_complete, w_end;
  logic [7:0]      w_rd_pass_inc;

  assign w_b      = bvalid & bready;
  assign w_ar     = arvalid & arready;
  assign w_rl     = rvalid & rready & rlast;
  assign w_hs     = w_b | w_ar | w_rl;
  assign w_in_wr  = (r_state == S_WR);
  assign w_in_rd  = (r_state == S_RD);
  assign w_active = w_in_wr | w_in_rd;

  // A start landing on the done cycle is dropped so status stays observable.
  assign w_accept  = (r_state == S_IDLE) & start & ~r_done;
  assign w_abort   = abort & (r_state != S_IDLE);
  assign w_timeout = w_active & ~w_hs & (r_wdog == c_WDOG_LAST);
  assign w_order   = (w_in_wr & ((w_b & (r_wr_cnt == c_WBURSTS)) |
                                 (w_ar & (r_wr_cnt < c_WBURSTS)))) |
                     (w_in_rd & w_b);

  assign w_rd_pass_inc = r_rd_pass + 8'd1;
  assign w_pass_wrap   = w_in_rd & w_rl & (r_rd_burst == c_RD_LAST);
  assign w_complete    = w_pass_wrap & (w_rd_pass_inc == r_passes);
  assign w_end         = w_abort | w_timeout | w_order | w_complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    tst_rstn    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_RST;
      end
      S_RST: begin
        busy = 1'b1;
        if (w_end) w_state_nxt = S_IDLE;
        else if (r_rst_cnt == c_RST_LAST) w_state_nxt = S_WR;
      end
      S_WR: begin
        busy     = 1'b1;
        tst_rstn = 1'b1;
        if (w_end) w_state_nxt = S_IDLE;
        else if (w_ar && (r_wr_cnt == c_WBURSTS)) w_state_nxt = S_RD;
      end
      S_RD: begin
        busy     = 1'b1;
        tst_rstn = 1'b1;
        if (w_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_rd_burst <= '0;
      r_rd_pass  <= '0;
      r_passes   <= '0;
      r_err      <= '0;
      r_wdog     <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_to  <= 1'b0;
      r_fail_ord <= 1'b0;
    end else begin
      r_done <= w_end;
      if (w_accept) begin
        r_rst_cnt  <= '0;
        r_wr_cnt   <= '0;
        r_rd_burst <= '0;
        r_rd_pass  <= '0;
        r_passes   <= (num_passes == 8'd0) ? 8'd1 : num_passes;
        r_err      <= '0;
        r_wdog     <= '0;
        r_pass     <= 1'b0;
        r_fail_to  <= 1'b0;
        r_fail_ord <= 1'b0;
      end else if (r_state != S_IDLE) begin
        if (r_state == S_RST) r_rst_cnt <= r_rst_cnt + 1'b1;
        if (error && (r_err != 16'hFFFF)) r_err <= r_err + 16'd1;
        if (w_in_wr && w_b) r_wr_cnt <= r_wr_cnt + 16'd1;
        if (w_in_rd && w_rl) begin
          if (w_pass_wrap) begin
            r_rd_burst <= '0;
            r_rd_pass  <= w_rd_pass_inc;
          end else begin
            r_rd_burst <= r_rd_burst + 16'd1;
          end
        end
        if (w_active) r_wdog <= w_hs ? 16'd0 : r_wdog + 16'd1;
        // Only the highest-priority termination cause is recorded.
        if (w_abort) begin
          r_pass <= 1'b0;
        end else if (w_timeout) begin
          r_fail_to <= 1'b1;
        end else if (w_order) begin
          r_fail_ord <= 1'b1;
        end else if (w_complete) begin
          r_pass <= (r_err == 16'd0) & ~error;
        end
      end
    end
  end

  assign done         = r_done;
  assign pass         = r_pass;
  assign fail_timeout = r_fail_to;
  assign fail_order   = r_fail_ord;
  assign wr_burst_cnt = r_wr_cnt;
  assign rd_pass_cnt  = r_rd_pass;
  assign err_cnt      = r_err;

endmodule

`default_nettype wire

// File: doc/axi_self_test_ctrl.md
AXI_SELF_TEST_CTRL -- requirements
Module: axi_self_test_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles the test master is held in reset after start (>=1).
REQ-002 SHALL have parameter WBURSTS, default 64: expected write bursts per run (1..65535).
REQ-003 SHALL have parameter RBURSTS_PER_PASS, default 64: read bursts forming one read pass (1..65535).
REQ-004 SHALL have parameter TIMEOUT, default 1024: watchdog limit in cycles without a monitored handshake (2..65535).
REQ-005 SHALL have ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  run request; honoured only in IDLE.
- abort  in  1  terminate run, any non-IDLE state.
- num_passes  in  8  read passes per run; sampled at start; 0 treated as 1.
- bvalid, bready  in  1 each  monitored AXI B channel of test master.
- arvalid, arready  in  1 each  monitored AXI AR channel.
- rvalid, rready, rlast  in  1 each  monitored AXI R channel.
- error  in  1  mismatch strobe from test master.
- tst_rstn  out  1  active-low reset driven to test master.
- busy  out  1  high in RST, WR, RD.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  run completed cleanly; held until next start.
- fail_timeout  out  1  watchdog expired; held until next start.
- fail_order  out  1  protocol phase violation; held until next start.
- wr_burst_cnt  out  16  B handshakes counted this run.
- rd_pass_cnt  out  8  completed read passes this run.
- err_cnt  out  16  cycles with error=1 while busy, saturating at 0xFFFF.

Function
REQ-006 SHALL implement FSM states IDLE, RST, WR, RD; tst_rstn SHALL be 1 exactly when state is WR or RD (decoded from registered state).
REQ-007 IDLE: start=1 -> RST next cycle; clear wr_burst_cnt, rd_pass_cnt, err_cnt, pass, fail_timeout, fail_order, watchdog; latch num_passes (0->1).
REQ-008 RST: stay exactly RST_CYCLES cycles, then WR.
REQ-009 Handshakes: B = bvalid&bready; AR = arvalid&arready; RL = rvalid&rready&rlast.
REQ-010 WR: each B increments wr_burst_cnt; B when wr_burst_cnt==WBURSTS -> fail_order; AR when wr_burst_cnt==WBURSTS -> RD; AR when wr_burst_cnt<WBURSTS -> fail_order.
REQ-011 RD: internal 16-bit burst counter increments on RL; on RL at RBURSTS_PER_PASS-1 it wraps to 0 and rd_pass_cnt increments; if new rd_pass_cnt equals latched passes -> run complete; B in RD -> fail_order.
REQ-012 Watchdog in WR/RD: increment per cycle with no B, AR or RL; clear on any; on reaching TIMEOUT-1 -> fail_timeout.
REQ-013 err_cnt SHALL increment on every busy cycle with error=1, saturating at 0xFFFF.
REQ-014 Run end (complete, fail_timeout, fail_order, abort): next state IDLE, done=1 for that one cycle, tst_rstn=0 from that cycle; pass=1 only on completion with err_cnt==0 and error=0 in the final cycle.
REQ-015 Same-cycle priority: abort > timeout > order violation > completion; abort sets no fail flag and pass=0.
REQ-016 start while busy SHALL be ignored; start coincident with done is ignored.
REQ-017 Counters SHALL hold in IDLE; status outputs SHALL hold their last values until next accepted start.

Reset
REQ-018 rst=1 SHALL force state IDLE and all outputs and internal counters to 0 at the next edge, overriding any other input, including mid-run.

Verification (RST_CYCLES=3, WBURSTS=4, RBURSTS_PER_PASS=4, TIMEOUT=32)
REQ-019 start, num_passes=2, 4 B, then AR/RL for 8 bursts, error=0 -> tst_rstn low 3 cycles after start acceptance, done pulse, pass=1, wr_burst_cnt=4, rd_pass_cnt=2, err_cnt=0.
REQ-020 Same run with error high 3 cycles in RD -> done, pass=0, err_cnt=3, no fail flag.
REQ-021 Stall after 2 B -> fail_timeout=1 and done 32 cycles after last B, wr_burst_cnt=2; AR after 2 B -> fail_order=1, done, pass=0.
REQ-022 abort in RD -> done, pass=0, both fail flags 0, tst_rstn=0; rst mid-WR -> all outputs 0 next cycle.
REQ-023 num_passes=0 -> completes after 4 RL with rd_pass_cnt=1; start pulsed during WR -> no effect on counters or state.
